// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring unsigned divider with load/Execute front panel
// One quotient bit per clock; the result is held until Execute is released.
module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             LoadA,
   input  logic             LoadB,
   input  logic             Execute,
   input  logic [WIDTH-1:0] Din,
   output logic [WIDTH-1:0] Aval,
   output logic [WIDTH-1:0] Bval,
   output logic             Busy,
   output logic             Done,
   output logic             DivByZero
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH:0]     a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   s_q, s_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               dbz_q, dbz_d;

   // Trial subtraction carries one extra bit so its msb is a true sign
   // even when the shifted partial remainder uses all WIDTH+1 bits.
   logic [WIDTH+1:0]   trial;

   assign trial = {a_q, b_q[WIDTH-1]} - {2'b00, s_q};

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         cnt_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         cnt_q   <= cnt_d;
         dbz_q   <= dbz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      cnt_d   = cnt_q;
      dbz_d   = dbz_q;
      unique case (state_q)
         IDLE: begin
            if (LoadA) b_d = Din;
            if (LoadB) s_d = Din;
            // Start decision uses the divisor as it stood before this edge.
            if (Execute) begin
               a_d     = '0;
               cnt_d   = '0;
               dbz_d   = (s_q == '0);
               state_d = RUN;
            end
         end
         RUN: begin
            if (!trial[WIDTH+1]) begin
               a_d = trial[WIDTH:0];
               b_d = {b_q[WIDTH-2:0], 1'b1};
            end else begin
               a_d = {a_q[WIDTH-1:0], b_q[WIDTH-1]};
               b_d = {b_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DONE;
         end
         DONE: begin
            if (!Execute) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign Aval      = a_q[WIDTH-1:0];
   assign Bval      = b_q;
   assign Busy      = (state_q == RUN);
   assign Done      = (state_q == DONE);
   assign DivByZero = dbz_q;

endmodule
